ictrl_cfg_sequencer: RTL and testbench

Command-driven sequencer in front of ictrl_send_recv_flit. It consumes a stream of descriptors (header flit plus N cache-config flits) and loads group/cache info into the flit block. It then triggers cfg_send_start, counts forked send handshakes until all config flits have left, and optionally waits for nodes_intr before the next descriptor. It reports completion, error and progress to the host register block.

---
 rtl/ictrl_cfg_sequencer_if.sv | 26 ++
 rtl/ictrl_cfg_sequencer.sv | 105 ++++++++++
 tb/tb_ictrl_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ictrl_cfg_sequencer_if.sv
// ictrl_cfg_sequencer_if: command stream, flit-block config push and send-tap bundle
interface ictrl_cfg_sequencer_if #(
  parameter int FLIT_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FLIT_WIDTH-1:0] cmd_data;
  logic                  cfg_send_start;
  logic [FLIT_WIDTH-1:0] cfg_group_info;
  logic                  cfg_group_info_valid;
  logic [FLIT_WIDTH-1:0] cfg_cache_info;
  logic                  cfg_cache_info_valid;
  logic [11:0]           send_valid;
  logic [11:0]           send_ready;
  logic                  nodes_intr;
  modport master (
    input  cmd_valid, cmd_data, send_valid, send_ready, nodes_intr,
    output cmd_ready, cfg_send_start, cfg_group_info, cfg_group_info_valid,
           cfg_cache_info, cfg_cache_info_valid
  );
  modport slave (
    output cmd_valid, cmd_data, send_valid, send_ready, nodes_intr,
    input  cmd_ready, cfg_send_start, cfg_group_info, cfg_group_info_valid,
           cfg_cache_info, cfg_cache_info_valid
  );
endinterface

// File: rtl/ictrl_cfg_sequencer.sv
// ictrl_cfg_sequencer: loads descriptor config flits into the flit block and tracks their sends
module ictrl_cfg_sequencer #(
  parameter int FLIT_WIDTH = 32,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seq_start,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  ictrl_cfg_sequencer_if.master bus,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 seq_err,
  output logic [1:0]           err_code,
  output logic [7:0]           desc_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, START, SEND, WAIT_INTR, DONE, ERR} state_t;
  state_t               state;
  logic [11:0]          mask;
  logic [3:0]           cnt;
  logic [3:0]           load_cnt;
  logic [3:0]           send_cnt;
  logic                 wait_intr;
  logic                 last;
  logic [TIMEOUT_W-1:0] timer;
  logic                 push;
  logic                 fire;
  assign push = state == LOAD && bus.cmd_valid;
  assign fire = |bus.send_valid && &(bus.send_ready | ~bus.send_valid);
  assign bus.cmd_ready = state == HDR || state == LOAD;
  assign bus.cfg_send_start = state == START;
  assign bus.cfg_cache_info_valid = push;
  assign bus.cfg_group_info_valid = push;
  assign bus.cfg_cache_info = push ? bus.cmd_data : '0;
  assign bus.cfg_group_info = push ? FLIT_WIDTH'(mask) : '0;
  assign busy = state != IDLE;
  assign seq_done = state == DONE;
  assign seq_err = state == ERR;
  // Descriptor walk: header latch, flit pass-through count, fire count, interrupt wait, status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      cnt       <= '0;
      load_cnt  <= '0;
      send_cnt  <= '0;
      wait_intr <= 1'b0;
      last      <= 1'b0;
      timer     <= '0;
      err_code  <= '0;
      desc_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (seq_start) begin
          state    <= HDR;
          desc_cnt <= '0;
          err_code <= '0;
        end
        HDR: if (bus.cmd_valid) begin
          mask      <= bus.cmd_data[11:0];
          cnt       <= bus.cmd_data[15:12];
          wait_intr <= bus.cmd_data[16];
          last      <= bus.cmd_data[17];
          load_cnt  <= '0;
          if (bus.cmd_data[15:12] == 4'd0) begin
            state    <= ERR;
            err_code <= 2'd1;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (bus.cmd_valid) begin
          load_cnt <= load_cnt + 4'd1;
          if (load_cnt == cnt - 4'd1) begin
            state    <= START;
            send_cnt <= '0;
          end
        end
        START, SEND: if (fire) begin
          send_cnt <= send_cnt + 4'd1;
          if (send_cnt + 4'd1 != cnt) begin
            state <= SEND;
          end else if (wait_intr) begin
            state <= WAIT_INTR;
            timer <= '0;
          end else begin
            desc_cnt <= desc_cnt + 8'd1;
            state    <= last ? DONE : HDR;
          end
        end
        WAIT_INTR: begin
          timer <= timer + TIMEOUT_W'(1);
          if (bus.nodes_intr) begin
            desc_cnt <= desc_cnt + 8'd1;
            state    <= last ? DONE : HDR;
          end else if (cfg_timeout != '0 && timer == cfg_timeout - TIMEOUT_W'(1)) begin
            state    <= ERR;
            err_code <= 2'd2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ictrl_cfg_sequencer.sv
// tb_ictrl_cfg_sequencer: descriptor-level model with per-cycle output comparison
module tb_ictrl_cfg_sequencer;
  localparam int FW = 32;
  localparam int TW = 16;
  typedef struct {
    logic [11:0] mask;
    logic [3:0]  cnt;
    logic        wt;
    logic        last;
    int          intr_at;
    int          rmode;
    int          rst_after;
  } desc_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seq_start = 1'b0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          busy, seq_done, seq_err;
  logic [1:0]    err_code;
  logic [7:0]    desc_cnt;
  ictrl_cfg_sequencer_if #(.FLIT_WIDTH(FW)) bus ();
  ictrl_cfg_sequencer #(.FLIT_WIDTH(FW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .cfg_timeout(cfg_timeout), .bus(bus),
    .busy(busy), .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code), .desc_cnt(desc_cnt)
  );
  always #5 clk = ~clk;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        e_busy, e_ready, e_start, e_done, e_err, e_push;
  logic [1:0]  e_code;
  logic [7:0]  e_desc;
  logic [31:0] q_data[$];
  logic [11:0] q_mask[$];
  int          pushes = 0;
  int          wait_err_len = 0;
  desc_t       dl[16];
  int          nd = 0;
  int          gap_max = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, e_ready});
    chk("cfg_send_start", {31'b0, bus.cfg_send_start}, {31'b0, e_start});
    chk("seq_done", {31'b0, seq_done}, {31'b0, e_done});
    chk("seq_err", {31'b0, seq_err}, {31'b0, e_err});
    chk("err_code", {30'b0, err_code}, {30'b0, e_code});
    chk("desc_cnt", {24'b0, desc_cnt}, {24'b0, e_desc});
    chk("cache_valid", {31'b0, bus.cfg_cache_info_valid}, {31'b0, e_push});
    chk("group_valid", {31'b0, bus.cfg_group_info_valid}, {31'b0, e_push});
    if (bus.cfg_cache_info_valid && q_data.size() == 0) begin
      chk("unexpected_push", 32'd1, 32'd0);
    end else if (bus.cfg_cache_info_valid) begin
      chk("cache_info", bus.cfg_cache_info, q_data.pop_front());
      chk("group_info", bus.cfg_group_info, {20'b0, q_mask.pop_front()});
      pushes++;
    end else begin
      chk("cache_info_idle", bus.cfg_cache_info, 32'd0);
      chk("group_info_idle", bus.cfg_group_info, 32'd0);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.nodes_intr = 1'b0;
    seq_start      = 1'b0;
    e_push         = 1'b0;
    e_done         = 1'b0;
    e_err          = 1'b0;
  endtask
  function automatic int gap();
    return gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0;
  endfunction
  function automatic logic [11:0] rdy_pat(input int mode, input int sc);
    if (mode == 2) return sc < 10 ? 12'h001 : 12'h005;
    if (mode == 1) return $urandom_range(0, 2) == 0 ? 12'hFFF : 12'($urandom);
    return 12'hFFF;
  endfunction
  task automatic add(input logic [11:0] m, input logic [3:0] c, input logic w, input logic l,
                     input int ia, input int rm, input int ra);
    dl[nd] = '{mask: m, cnt: c, wt: w, last: l, intr_at: ia, rmode: rm, rst_after: ra};
    nd++;
  endtask
  task automatic junk_cmd();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_data  = $urandom;
  endtask
  task automatic success(input logic l);
    e_desc = e_desc + 8'd1;
    if (l) begin
      e_busy = 1'b1;
      e_ready = 1'b0;
      e_done = 1'b1;
      cyc();
      e_busy = 1'b0;
    end else begin
      e_ready = 1'b1;
    end
  endtask
  task automatic run_seq();
    logic [11:0] rdy;
    int fires;
    int sc;
    junk_cmd();
    seq_start = 1'b1;
    cyc();
    e_busy = 1'b1;
    e_ready = 1'b1;
    e_code = 2'd0;
    e_desc = 8'd0;
    for (int d = 0; d < nd; d++) begin
      repeat (gap()) cyc();
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = {14'($urandom), dl[d].last, dl[d].wt, dl[d].cnt, dl[d].mask};
      cyc();
      if (dl[d].cnt == 4'd0) begin
        e_ready = 1'b0;
        e_err = 1'b1;
        e_code = 2'd1;
        cyc();
        e_busy = 1'b0;
        return;
      end
      for (int i = 0; i < int'(dl[d].cnt); i++) begin
        repeat (gap()) cyc();
        if (i == dl[d].rst_after) begin
          rst = 1'b1;
          cyc();
          rst = 1'b0;
          e_busy = 1'b0;
          e_ready = 1'b0;
          e_code = 2'd0;
          e_desc = 8'd0;
          return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = $urandom;
        e_push = 1'b1;
        q_data.push_back(bus.cmd_data);
        q_mask.push_back(dl[d].mask);
        cyc();
      end
      e_ready = 1'b0;
      bus.send_valid = dl[d].mask;
      fires = 0;
      sc = 0;
      while (fires < int'(dl[d].cnt) && sc < 2000) begin
        rdy = rdy_pat(dl[d].rmode, sc);
        bus.send_ready = rdy;
        e_start = fires == 0;
        junk_cmd();
        cyc();
        sc++;
        if (&(rdy | ~dl[d].mask)) fires++;
      end
      if (sc >= 2000) chk("send_budget", 32'(sc), 32'd0);
      bus.send_valid = '0;
      bus.send_ready = '0;
      e_start = 1'b0;
      if (dl[d].wt) begin
        for (int t = 0; t < 5000; t++) begin
          junk_cmd();
          if (t == dl[d].intr_at) begin
            bus.nodes_intr = 1'b1;
            cyc();
            break;
          end
          cyc();
          if (cfg_timeout != '0 && t == int'(cfg_timeout) - 1) begin
            wait_err_len = t + 1;
            e_err = 1'b1;
            e_code = 2'd2;
            cyc();
            e_busy = 1'b0;
            return;
          end
          if (t == 4999) chk("wait_budget", 32'(t), 32'd0);
        end
      end
      success(dl[d].last);
      if (dl[d].last) return;
    end
  endtask
  initial begin
    int p0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.send_valid = '0;
    bus.send_ready = '0;
    bus.nodes_intr = 1'b0;
    {e_busy, e_ready, e_start, e_done, e_err, e_push} = '0;
    e_code = '0;
    e_desc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) cyc();
    nd = 0;
    add(12'h00F, 4'd3, 1'b0, 1'b1, -1, 0, -1);
    run_seq();
    cyc();
    chk("t1_pushes", 32'(pushes), 32'd3);
    chk("t1_desc", {24'b0, desc_cnt}, 32'd1);
    chk("t1_code", {30'b0, err_code}, 32'd0);
    nd = 0;
    add(12'h003, 4'd2, 1'b1, 1'b0, 20, 0, -1);
    add(12'h0C0, 4'd1, 1'b0, 1'b1, -1, 0, -1);
    run_seq();
    cyc();
    chk("t2_desc", {24'b0, desc_cnt}, 32'd2);
    nd = 0;
    add(12'h005, 4'd2, 1'b0, 1'b1, -1, 2, -1);
    run_seq();
    cyc();
    chk("t3_desc", {24'b0, desc_cnt}, 32'd1);
    p0 = pushes;
    nd = 0;
    add(12'h00F, 4'd0, 1'b0, 1'b1, -1, 0, -1);
    run_seq();
    cyc();
    chk("t4_code", {30'b0, err_code}, 32'd1);
    chk("t4_no_push", 32'(pushes - p0), 32'd0);
    cfg_timeout = 16'd8;
    nd = 0;
    add(12'h001, 4'd1, 1'b1, 1'b1, -1, 0, -1);
    run_seq();
    cyc();
    chk("t5_wait_len", 32'(wait_err_len), 32'd8);
    chk("t5_code", {30'b0, err_code}, 32'd2);
    nd = 0;
    add(12'h001, 4'd1, 1'b1, 1'b1, 7, 0, -1);
    run_seq();
    cyc();
    chk("t5b_desc", {24'b0, desc_cnt}, 32'd1);
    chk("t5b_code", {30'b0, err_code}, 32'd0);
    cfg_timeout = '0;
    nd = 0;
    add(12'h0FF, 4'd5, 1'b0, 1'b1, -1, 0, 2);
    run_seq();
    chk("t6_busy", {31'b0, busy}, 32'd0);
    cyc();
    nd = 0;
    add(12'h0A0, 4'd4, 1'b0, 1'b1, -1, 1, -1);
    run_seq();
    cyc();
    chk("t6_rerun_desc", {24'b0, desc_cnt}, 32'd1);
    gap_max = 2;
    for (int s = 0; s < 30; s++) begin
      int n;
      n = $urandom_range(1, 4);
      nd = 0;
      cfg_timeout = $urandom_range(0, 1) ? 16'($urandom_range(5, 15)) : 16'd0;
      for (int k = 0; k < n; k++) begin
        add(12'($urandom_range(1, 4095)),
            $urandom_range(0, 19) == 0 ? 4'd0 : 4'($urandom_range(1, 15)),
            1'($urandom_range(0, 1)), k == n - 1, int'($urandom_range(0, 14)), 1, -1);
      end
      run_seq();
      repeat ($urandom_range(1, 3)) begin
        junk_cmd();
        cyc();
      end
      chk("rand_queue_drained", 32'(q_data.size()), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
